mont_arbiter: RTL

Round-robin arbiter and sequencer that shares one `montgomery` multiplier instance between `NUM_REQ` requesters, for example the NTT butterfly and basemul datapaths. It accepts operand pairs through a valid/ready handshake and issues each pair to the multiplier as a single-cycle start pulse. It waits for the multiplier's done pulse, then returns the 12-bit result to the owning requester as a one-hot response pulse. The block sits between the polynomial-arithmetic datapaths and the single shared multiplier; the multiplier is instantiated beside it, not inside it.

---
 rtl/mont_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/mont_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared constants and FSM state type for the Montgomery multiplier arbiter
package mont_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int COEF_W      = 12;
    localparam int MONT_R_MODQ = 767;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant; search starts one past the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester after ptr wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                gnt = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/mont_arbiter.sv
// rtl/mont_arbiter.sv - shares one montgomery multiplier between NUM_REQ requesters; MONT_ARB_WDOG_EN adds a WAIT watchdog
module mont_arbiter
    import mont_pkg::*;
#(
    parameter int NUM_REQ = 2
`ifdef MONT_ARB_WDOG_EN
    ,
    parameter int WDOG_LIMIT = 15
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [COEF_W*NUM_REQ-1:0] i_req_a,
    input  logic [COEF_W*NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [COEF_W-1:0]         o_rsp_c,
    output logic                      o_busy,
    output logic                      o_err,
    output logic                      o_mm_en,
    output logic [COEF_W-1:0]         o_mm_a,
    output logic [COEF_W-1:0]         o_mm_b,
    input  logic [COEF_W-1:0]         i_mm_c,
    input  logic                      i_mm_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [COEF_W-1:0]  rsp_c_q, rsp_c_d;
    logic [COEF_W-1:0]  mm_a_q, mm_a_d;
    logic [COEF_W-1:0]  mm_b_q, mm_b_d;
    logic               mm_en_q, mm_en_d;
    logic               busy_q, busy_d;
`ifdef MONT_ARB_WDOG_EN
    logic [3:0]         wdog_q, wdog_d;
    logic               err_q, err_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (i_req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Grant is only offered in IDLE and is held low while reset is asserted.
    assign o_req_ready = (state_q == IDLE && i_rstn) ? gnt : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        mm_en_d     = 1'b0;
        mm_a_d      = '0;
        mm_b_d      = '0;
        rsp_valid_d = '0;
        rsp_c_d     = '0;
`ifdef MONT_ARB_WDOG_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt[i]) begin
                            mm_a_d  = i_req_a[i*COEF_W +: COEF_W];
                            mm_b_d  = i_req_b[i*COEF_W +: COEF_W];
                            owner_d = PTR_W'(i);
                        end
                    end
                    ptr_d   = owner_d;
                    mm_en_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MONT_ARB_WDOG_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (i_mm_done) begin
                    rsp_c_d              = i_mm_c;
                    rsp_valid_d[owner_q] = 1'b1;
                    busy_d               = 1'b0;
                    state_d              = IDLE;
                end
`ifdef MONT_ARB_WDOG_EN
                else begin
                    // Abandon the operation silently; the owner never sees a response.
                    wdog_d = wdog_q + 4'd1;
                    if (wdog_d == 4'(WDOG_LIMIT)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            owner_q     <= '0;
            busy_q      <= 1'b0;
            mm_en_q     <= 1'b0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            rsp_valid_q <= '0;
            rsp_c_q     <= '0;
`ifdef MONT_ARB_WDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mm_en_q     <= mm_en_d;
            mm_a_q      <= mm_a_d;
            mm_b_q      <= mm_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
`ifdef MONT_ARB_WDOG_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_c     = rsp_c_q;
    assign o_busy      = busy_q;
    assign o_mm_en     = mm_en_q;
    assign o_mm_a      = mm_a_q;
    assign o_mm_b      = mm_b_q;
`ifdef MONT_ARB_WDOG_EN
    assign o_err       = err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule
